sort_stack_ctrl: RTL and testbench
==================================

Name: sort_stack_ctrl

Overview:
- Sequencer for the systolic sorting stack (R_SZ-entry insertion sorter; max value appears on its data output).
- Accepts a stream sequence on a valid/ready input, drives the stack's load phase, then pops the sorted sequence in descending order on a valid/ready output.
- Owns initial flush of stack contents, turnaround timing, backpressure via the stack hold line, and overflow handling.
- Sits between the upstream producer and downstream consumer, one instance per sorting stack.

Parameters:
- HBIT, 63, MSB index of data word; width is HBIT+1; unsigned.
- R_SZ, 256, stack capacity in elements; must match the controlled stack.
- TURN_CYC, 1, idle cycles between last load and first pop (is_input=0, hold=1); range 1..7.
- CW, $clog2(R_SZ+1), element-counter width; derived, do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input element valid.
- s_ready  out  1  controller accepts input element.
- s_data  in  HBIT+1  input element.
- s_last  in  1  marks last element of a sequence; qualified by s_valid.
- m_valid  out  1  sorted output element valid.
- m_ready  in  1  consumer accepts output element.
- m_data  out  HBIT+1  sorted output element, descending order.
- m_last  out  1  marks last sorted element; qualified by m_valid.
- stk_hold  out  1  to stack: 1 freezes stack state.
- stk_is_input  out  1  to stack: 1 = load phase.
- stk_data_in  out  HBIT+1  to stack: element being loaded.
- stk_data_out  in  HBIT+1  from stack: current maximum.
- busy  out  1  1 in any state other than LOAD with count==0.
- ovf  out  1  one-cycle pulse when a sequence exceeds R_SZ elements.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state changes happen on the rising edge of clk.
- Stack contract:
  - Cycle with is_input=1 and hold=0 inserts stk_data_in.
  - Cycle with is_input=0 and hold=0 removes the current max; the next max is visible on stk_data_out the following cycle.
  - hold=1 freezes the stack.
  - Zeros shift in from the tail.
  - The stack has no reset, so the controller flushes it.
- States: FLUSH, LOAD, TURN, POP. Reset forces FLUSH with count=0.
- Reset values: s_ready=0, m_valid=0, m_last=0, stk_is_input=1, stk_hold=0, stk_data_in=0, ovf=0, busy=1. m_data follows stk_data_out and is don't-care while m_valid=0.
- FLUSH:
  - is_input=1, hold=0, data_in=0 for exactly R_SZ cycles; every cell then holds 0.
  - s_ready=0.
  - Then go to LOAD.
  - Zero is the minimum unsigned value, so residual zeros never displace real data.
- LOAD:
  - s_ready=1, is_input=1, stk_data_in=s_data, stk_hold=!s_valid.
  - Each handshake increments count.
  - Handshake with s_last=1 → TURN.
  - Handshake bringing count to R_SZ with s_last=0 → ovf pulse, s_ready drops, go to TURN. The count stays R_SZ, and all further input beats up to and including s_last are dropped by a discard flag.
  - While discarding, s_ready=1 and the stack is held.
  - The discard flag clears on the s_last handshake; LOAD of the next sequence is not entered until then.
- TURN:
  - is_input=0, hold=1 for TURN_CYC cycles; s_ready=0, m_valid=0.
  - Then go to POP.
- POP:
  - m_valid=1, m_data=stk_data_out (combinational), m_last=(count==1).
  - stk_hold = !(m_valid&&m_ready); each handshake decrements count.
  - Handshake with m_last → LOAD. Remaining cells are all zero, so no re-flush is needed.
  - m_data stays stable while m_ready=0.
- Latency:
  - First m_valid occurs TURN_CYC+1 cycles after the s_last handshake.
  - Throughput is one element per cycle in both directions under no stall.
- Sequence length: 1..R_SZ elements. A lone element with s_last is a legal sequence.
- Reset asserted mid-operation: state, count and discard are abandoned, outputs take reset values the next cycle, and a full FLUSH is redone.

Test Plan:
- rst 1 cycle, then count cycles → s_ready=0 for exactly R_SZ cycles after reset release; s_ready=1 on cycle R_SZ. (R_SZ=8 bench variant: 8 cycles.)
- Load 5,1,9,3,7 (s_last on 7), m_ready=1 → m_data 9,7,5,3,1 on consecutive cycles; m_last with 1; first m_valid 2 cycles after the s_last beat.
- Same load with m_ready toggling 1,0,0,1,... → no duplicates or losses; m_data stable while stalled; stk_hold=1 on stall cycles.
- R_SZ=8 variant, feed 10 elements, s_last on 10th → ovf pulses on 8th accept; 9th and 10th are dropped; output is the 8 sorted values with m_last on 8th.
- Single element 0x42 with s_last → one output 0x42 with m_last=1; a second sequence 2,2,0 then pops 2,2,0 correctly.
- rst asserted during POP after 2 of 5 pops → m_valid=0 next cycle, FLUSH repeated; a new sequence 4,8 pops 8,4 with no stale data.

Source files
------------

// File: rtl/sort_stack_ctrl.sv
// -----------------------------------------------------------------------------
// sort_stack_ctrl
//
// Sequencer for an R_SZ-entry systolic insertion sorting stack. It flushes the
// stack with zeros after reset, loads one input sequence, waits a short
// turnaround, and then pops the sequence back out largest-first.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   s_valid/s_ready   input element handshake; s_data is the element, s_last
//                     marks the final element of a sequence
//   m_valid/m_ready   sorted output handshake; m_data is the element (descending
//                     order), m_last marks the final element
//   stk_hold          to stack: 1 freezes the stack for this cycle
//   stk_is_input      to stack: 1 = insert stk_data_in, 0 = pop current maximum
//   stk_data_in       to stack: element being inserted
//   stk_data_out      from stack: current maximum
//   busy              1 unless idle in LOAD with no elements loaded
//   ovf               one-cycle pulse when a sequence exceeds R_SZ elements
// -----------------------------------------------------------------------------
module sort_stack_ctrl #(
  parameter int HBIT     = 63,
  parameter int R_SZ     = 256,
  parameter int TURN_CYC = 1,
  parameter int CW       = $clog2(R_SZ + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [HBIT:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [HBIT:0] m_data,
  output logic          m_last,
  output logic          stk_hold,
  output logic          stk_is_input,
  output logic [HBIT:0] stk_data_in,
  input  logic [HBIT:0] stk_data_out,
  output logic          busy,
  output logic          ovf
);

  typedef enum logic [1:0] {FLUSH, LOAD, TURN, POP} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(R_SZ - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [2:0]    TURN_END = 3'(TURN_CYC - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [2:0]    turn_cnt;
  logic          discard;
  logic          ovf_q;
  logic          s_fire;
  logic          m_fire;

  // Handshake-level outputs are decoded purely from registered state, so they
  // never depend combinationally on the upstream/downstream valid/ready lines.
  // During discard the input side keeps accepting (and dropping) beats until
  // s_last, except in TURN where the input is always closed.
  assign s_ready      = (state == LOAD) || ((state == POP) && discard);
  assign m_valid      = (state == POP);
  assign m_last       = (state == POP) && (count == ONE);
  assign m_data       = stk_data_out;
  assign stk_is_input = (state == FLUSH) || (state == LOAD);
  assign stk_data_in  = (state == LOAD) ? s_data : '0;
  assign busy         = !((state == LOAD) && (count == '0));
  assign ovf          = ovf_q;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  // The stack advances only on a real handshake: a load needs a valid beat
  // that is not being discarded, a pop needs the consumer to take the data.
  // Holding it otherwise keeps m_data stable under backpressure.
  always_comb begin
    stk_hold = 1'b0;
    case (state)
      FLUSH:   stk_hold = 1'b0;
      LOAD:    stk_hold = discard || !s_valid;
      TURN:    stk_hold = 1'b1;
      POP:     stk_hold = !m_ready;
      default: stk_hold = 1'b0;
    endcase
  end

  // Main sequencer. In FLUSH the element counter doubles as the flush cycle
  // counter since no elements are held yet. An overflowing sequence keeps
  // count at R_SZ (the stack really holds R_SZ elements) and sets discard so
  // the tail of that sequence, up to its s_last, is swallowed in any state.
  // After the final pop every cell is zero again, so LOAD is re-entered
  // without another flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FLUSH;
      count    <= '0;
      turn_cnt <= '0;
      discard  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (discard && s_fire && s_last) begin
        discard <= 1'b0;
      end
      case (state)
        FLUSH: begin
          if (count == LAST_IDX) begin
            count <= '0;
            state <= LOAD;
          end else begin
            count <= count + ONE;
          end
        end
        LOAD: begin
          if (s_fire && !discard) begin
            count <= count + ONE;
            if (s_last) begin
              turn_cnt <= '0;
              state    <= TURN;
            end else if (count == LAST_IDX) begin
              ovf_q    <= 1'b1;
              discard  <= 1'b1;
              turn_cnt <= '0;
              state    <= TURN;
            end
          end
        end
        TURN: begin
          if (turn_cnt == TURN_END) begin
            state <= POP;
          end else begin
            turn_cnt <= turn_cnt + 3'd1;
          end
        end
        POP: begin
          if (m_fire) begin
            count <= count - ONE;
            if (count == ONE) begin
              state <= LOAD;
            end
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sort_stack_ctrl
//
// Bench for sort_stack_ctrl with a small stack (R_SZ=8). A behavioural stack
// model sits on the stk_* ports. Each issued sequence pushes its expected
// sorted output into a scoreboard queue; a negedge monitor pops and compares
// on every output handshake and also watches stall stability and latency.
// -----------------------------------------------------------------------------
module tb_sort_stack_ctrl;

  localparam int HBIT     = 15;
  localparam int W        = HBIT + 1;
  localparam int R_SZ     = 8;
  localparam int TURN_CYC = 1;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         stk_hold;
  logic         stk_is_input;
  logic [W-1:0] stk_data_in;
  logic [W-1:0] stk_data_out;
  logic         busy;
  logic         ovf;

  sort_stack_ctrl #(
    .HBIT(HBIT),
    .R_SZ(R_SZ),
    .TURN_CYC(TURN_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .stk_hold(stk_hold),
    .stk_is_input(stk_is_input),
    .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out),
    .busy(busy),
    .ovf(ovf)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] seq_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           beat_cyc = 0;
  bit           lat_armed = 0;
  int           ovf_seen = 0;
  int           ovf_exp = 0;
  int           mode = 0;
  int           ph = 0;
  bit           prev_stall = 0;
  bit           prev_valid = 0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] cells [R_SZ];
  bit           stk_init = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stack: inserts enter at the head and the oldest cell falls off
  // the tail; a pop removes the largest cell and a zero enters at the tail.
  // Contents start random because the real stack has no reset.
  always @(posedge clk) begin : stack_model
    logic [W-1:0] nxt [R_SZ];
    int k;
    if (!stk_init) begin
      for (int i = 0; i < R_SZ; i++) cells[i] <= W'($urandom);
      stk_init <= 1'b1;
    end else if (!stk_hold) begin
      if (stk_is_input) begin
        for (int i = R_SZ - 1; i > 0; i--) nxt[i] = cells[i-1];
        nxt[0] = stk_data_in;
      end else begin
        k = 0;
        for (int i = R_SZ - 1; i >= 0; i--) if (cells[i] == stk_data_out) k = i;
        for (int i = 0; i < R_SZ; i++) begin
          if (i < k) nxt[i] = cells[i];
          else if (i + 1 < R_SZ) nxt[i] = cells[i+1];
          else nxt[i] = '0;
        end
      end
      cells <= nxt;
    end
  end

  always_comb begin
    stk_data_out = '0;
    for (int i = 0; i < R_SZ; i++) if (cells[i] > stk_data_out) stk_data_out = cells[i];
  end

  // Consumer-side ready pattern generator; mode 0 leaves m_ready to the main
  // process for hand-driven scenarios.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: m_ready = 1'b1;
        2: begin
          m_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        3: m_ready = ($urandom_range(0, 2) != 0);
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: scoreboard compare on each handshake, plus stall and
  // turnaround-latency checks.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 0;
      prev_valid = 0;
    end else begin
      if (ovf) ovf_seen++;
      if (m_valid && !prev_valid && lat_armed) begin
        checkOutput("latency", 64'(cyc - beat_cyc), 64'(TURN_CYC + 1));
        lat_armed = 0;
      end
      if (m_valid && prev_stall) checkOutput("stall_data", 64'(m_data), 64'(prev_data));
      if (m_valid && !m_ready) checkOutput("stall_hold", 64'(stk_hold), 64'd1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_output", 64'(m_data), 64'hdead);
        end else begin
          e = exp_q.pop_front();
          checkOutput("m_data", 64'(m_data), 64'(e.d));
          checkOutput("m_last", 64'(m_last), 64'(e.l));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_valid = m_valid;
    end
  end

  // Reset for one cycle, check reset values, then measure the flush length.
  task automatic doReset();
    int n;
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    lat_armed = 0;
    @(negedge clk);
    checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_m_last", 64'(m_last), 64'd0);
    checkOutput("rst_is_input", 64'(stk_is_input), 64'd1);
    checkOutput("rst_hold", 64'(stk_hold), 64'd0);
    checkOutput("rst_data_in", 64'(stk_data_in), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd1);
    n = 0;
    while (!s_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("flush_cycles", 64'(n), 64'(R_SZ));
    checkOutput("idle_busy", 64'(busy), 64'd0);
  endtask

  // Drive seq_q as one sequence; the expected sorted output (first R_SZ
  // elements, largest first) is queued before the first beat goes out.
  task automatic applyStimulus(input bit gaps);
    logic [W-1:0] srt[$];
    logic [W-1:0] t;
    exp_t e;
    int len, keep, waitc;
    bit ovf_pending;
    len = seq_q.size();
    keep = (len > R_SZ) ? R_SZ : len;
    for (int i = 0; i < keep; i++) srt.push_back(seq_q[i]);
    for (int i = 0; i < keep; i++)
      for (int j = 0; j < keep - 1 - i; j++)
        if (srt[j] < srt[j+1]) begin
          t = srt[j];
          srt[j] = srt[j+1];
          srt[j+1] = t;
        end
    for (int i = 0; i < keep; i++) begin
      e.d = srt[i];
      e.l = (i == keep - 1);
      exp_q.push_back(e);
    end
    if (len > R_SZ) ovf_exp++;
    ovf_pending = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < len; i++) begin
      if (gaps && !ovf_pending && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = seq_q[i];
      s_last  = (i == len - 1);
      waitc = 0;
      forever begin
        @(negedge clk);
        if (ovf_pending) begin
          checkOutput("ovf_pulse", 64'(ovf), 64'd1);
          ovf_pending = 0;
        end
        if (s_ready) break;
        waitc++;
        if (waitc > 1000) break;
        @(posedge clk);
        #1;
      end
      if (waitc > 1000) begin
        checkOutput("s_ready_timeout", 64'(s_ready), 64'd1);
        s_valid = 1'b0;
        s_last = 1'b0;
        return;
      end
      if (i == len - 1 && len <= R_SZ) begin
        beat_cyc = cyc;
        lat_armed = 1;
      end
      if (i == R_SZ - 1 && len > R_SZ) ovf_pending = 1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    seq_q.delete();
  endtask

  // Wait for the scoreboard to empty, then confirm the controller is idle.
  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    checkOutput("end_busy", 64'(busy), 64'd0);
  endtask

  task automatic pushSeq5();
    seq_q = '{16'd5, 16'd1, 16'd9, 16'd3, 16'd7};
  endtask

  // Main scenario list: flush length, basic sort, stalled sort, overflow,
  // single-element and duplicate sequences, reset mid-pop, then random traffic.
  initial begin
    int n;
    int len;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    doReset();

    mode = 1;
    pushSeq5();
    applyStimulus(0);
    waitDrain();

    mode = 2;
    pushSeq5();
    applyStimulus(0);
    waitDrain();

    mode = 1;
    seq_q = '{16'd3, 16'd14, 16'd15, 16'd9, 16'd2, 16'd6, 16'd5, 16'd35, 16'd8, 16'd97};
    applyStimulus(0);
    waitDrain();
    checkOutput("ovf_count_a", 64'(ovf_seen), 64'(ovf_exp));

    seq_q = '{16'h42};
    applyStimulus(0);
    waitDrain();
    seq_q = '{16'd2, 16'd2, 16'd0};
    applyStimulus(0);
    waitDrain();

    mode = 0;
    m_ready = 1'b0;
    pushSeq5();
    applyStimulus(0);
    m_ready = 1'b1;
    n = 0;
    for (int w = 0; w < 100 && n < 2; w++) begin
      @(negedge clk);
      if (m_valid) n++;
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    checkOutput("pre_reset_pops", 64'(n), 64'd2);
    doReset();
    mode = 1;
    seq_q = '{16'd4, 16'd8};
    applyStimulus(0);
    waitDrain();

    mode = 3;
    for (int s = 0; s < 20; s++) begin
      len = $urandom_range(1, R_SZ + 3);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 0) seq_q.push_back(W'($urandom_range(0, 7)));
        else seq_q.push_back(W'($urandom));
      end
      applyStimulus(1);
      waitDrain();
    end
    checkOutput("ovf_count", 64'(ovf_seen), 64'(ovf_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
